// File: rtl/counter_pkg.sv
// Shared types and default width for the timer controller and its counter core.
package counter_pkg;

  localparam int N_BITS = 8;

  typedef enum logic [1:0] {
    START = 2'd0,
    STOP  = 2'd1,
    LOAD  = 2'd2,
    CLEAR = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Command channel of the timer controller: valid/ready handshake plus opcode, payload and mode.
interface timer_ctrl_if #(
  parameter int N_BITS = counter_pkg::N_BITS
);
  import counter_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_t           cmd_op;
  logic [N_BITS-1:0] cmd_data;
  logic              periodic;

  modport master (
    output cmd_valid, cmd_op, cmd_data, periodic,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, periodic,
    output cmd_ready
  );

endinterface

// File: rtl/timer_core.sv
// Count register with its active/shadow terminal pair: increment, terminal compare and reload.
module timer_core
  import counter_pkg::*;
#(
  parameter int N_BITS = counter_pkg::N_BITS
) (
  input  logic              clk,
  input  logic              syn_rst,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  input  logic              act_reload,
  input  logic              load_en,
  input  logic              load_now,
  input  logic [N_BITS-1:0] load_data,
  output logic [N_BITS-1:0] count,
  output logic              at_term
);

  logic [N_BITS-1:0] term_active;
  logic [N_BITS-1:0] term_shadow;

  assign at_term = (count == term_active);

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      count       <= '0;
      term_active <= '1;
      term_shadow <= '1;
    end else begin
      if (cnt_clr) begin
        count <= '0;
      end else if (cnt_inc) begin
        count <= count + 1'b1;
      end

      if (load_en) begin
        term_shadow <= load_data;
      end

      // A LOAD outside RUN takes effect at once; inside RUN it waits for the next wrap.
      if (load_en && load_now) begin
        term_active <= load_data;
      end else if (act_reload) begin
        term_active <= term_shadow;
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: command FSM, handshake and optional prescaler (TIMER_CTRL_PRESCALER_EN).
module timer_ctrl
  import counter_pkg::*;
#(
  parameter int N_BITS = counter_pkg::N_BITS
`ifdef TIMER_CTRL_PRESCALER_EN
  , parameter int PRESC_DIV = 4
`endif
) (
  input  logic              clk,
  input  logic              syn_rst,
  timer_ctrl_if.slave       cmd,
  output logic [N_BITS-1:0] count,
  output logic              busy,
  output logic              ripple,
  output logic              done
);

  state_t state;
  logic   per_q;
  logic   at_term;
  logic   tick;
  logic   cmd_acc;
  logic   cmd_start;
  logic   cmd_stop;
  logic   cmd_load;
  logic   cmd_clear;
  logic   start_idle;
  logic   term_hit;
  logic   wrap;

  // Commands are refused during reset and while a terminal event is pending.
  assign cmd.cmd_ready = !syn_rst && !((state == RUN) && at_term);

  assign cmd_acc    = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_start  = cmd_acc && (cmd.cmd_op == START);
  assign cmd_stop   = cmd_acc && (cmd.cmd_op == STOP);
  assign cmd_load   = cmd_acc && (cmd.cmd_op == LOAD);
  assign cmd_clear  = cmd_acc && (cmd.cmd_op == CLEAR);
  assign start_idle = cmd_start && (state == IDLE);
  assign term_hit   = tick && at_term;
  assign wrap       = term_hit && per_q;

`ifdef TIMER_CTRL_PRESCALER_EN
  // PRESC_DIV must be at least 2 so the divider register has a non-zero width.
  localparam int PW = $clog2(PRESC_DIV);

  logic [PW-1:0] presc;
  logic          presc_wrap;

  assign presc_wrap = (presc == PW'(PRESC_DIV - 1));
  assign tick       = (state == RUN) && presc_wrap;

  always_ff @(posedge clk) begin
    if (syn_rst || cmd_clear || start_idle) begin
      presc <= '0;
    end else if ((state == RUN) && !cmd_stop) begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
    end
  end
`else
  assign tick = (state == RUN);
`endif

  timer_core #(
    .N_BITS (N_BITS)
  ) u_core (
    .clk        (clk),
    .syn_rst    (syn_rst),
    .cnt_clr    (cmd_clear || start_idle || wrap),
    .cnt_inc    (tick && !at_term && !cmd_stop && !cmd_clear),
    .act_reload (start_idle || wrap),
    .load_en    (cmd_load),
    .load_now   (state != RUN),
    .load_data  (cmd.cmd_data),
    .count      (count),
    .at_term    (at_term)
  );

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state  <= IDLE;
      per_q  <= 1'b0;
      busy   <= 1'b0;
      ripple <= 1'b0;
      done   <= 1'b0;
    end else begin
      ripple <= 1'b0;
      done   <= 1'b0;
      if (cmd_clear) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_start) begin
              state <= RUN;
              per_q <= cmd.periodic;
              busy  <= 1'b1;
            end
          end
          HOLD: begin
            if (cmd_start) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            if (cmd_stop) begin
              state <= HOLD;
              busy  <= 1'b0;
            end else if (term_hit) begin
              if (per_q) begin
                ripple <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a cycle model feeding an expected-output queue.
module tb_timer_ctrl;
  import counter_pkg::*;

  localparam int NB = 8;
`ifdef TIMER_CTRL_PRESCALER_EN
  localparam int PD = 4;
`endif

  typedef struct packed {
    logic [NB-1:0] cnt;
    logic          busy;
    logic          rip;
    logic          dn;
  } exp_t;

  logic          clk = 1'b0;
  logic          syn_rst;
  logic [NB-1:0] count;
  logic          busy;
  logic          ripple;
  logic          done;

  timer_ctrl_if #(.N_BITS(NB)) cmd_bus ();

  timer_ctrl #(
    .N_BITS (NB)
`ifdef TIMER_CTRL_PRESCALER_EN
    , .PRESC_DIV (PD)
`endif
  ) dut (
    .clk     (clk),
    .syn_rst (syn_rst),
    .cmd     (cmd_bus),
    .count   (count),
    .busy    (busy),
    .ripple  (ripple),
    .done    (done)
  );

  always #5 clk = ~clk;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  logic          last_ready;
  state_t        m_st;
  logic [NB-1:0] m_cnt, m_term, m_sh;
  logic          m_per;
  int            m_pre;

  int seq3[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
  int rip3[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 0, 1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_count"},  count,  e.cnt);
    chk({tag, "_busy"},   busy,   e.busy);
    chk({tag, "_ripple"}, ripple, e.rip);
    chk({tag, "_done"},   done,   e.dn);
  endtask

  task automatic reset_cyc(input logic v, input cmd_op_t op);
    exp_t e;
    syn_rst = 1'b1;
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_op    = op;
    #1;
    chk("rst_ready", cmd_bus.cmd_ready, 0);
    e = '0;
    q.push_back(e);
    @(posedge clk);
    #1;
    syn_rst = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    m_st = IDLE; m_cnt = '0; m_term = '1; m_sh = '1; m_per = 1'b0; m_pre = 0;
    compare_out("rst");
  endtask

  task automatic cyc(input logic v, input cmd_op_t op, input logic [NB-1:0] d, input logic p);
    exp_t          e;
    logic          rdy, acc, tick, halt;
    state_t        n_st;
    logic [NB-1:0] n_cnt, n_term, n_sh;
    logic          n_per;
    int            n_pre;
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_data  = d;
    cmd_bus.periodic  = p;
    #1;
    last_ready = cmd_bus.cmd_ready;
    rdy = !((m_st == RUN) && (m_cnt == m_term));
    chk("cmd_ready", cmd_bus.cmd_ready, rdy);
    acc = v && rdy;
    n_st = m_st; n_cnt = m_cnt; n_term = m_term; n_sh = m_sh; n_per = m_per; n_pre = m_pre;
    e = '0;
    halt = 1'b0;
    if (acc) begin
      case (op)
        CLEAR: begin n_st = IDLE; n_cnt = '0; n_pre = 0; halt = 1'b1; end
        LOAD:  begin n_sh = d; if (m_st != RUN) n_term = d; end
        START: begin
          if (m_st == IDLE) begin
            n_st = RUN; n_cnt = '0; n_per = p; n_term = m_sh; n_pre = 0;
          end else if (m_st == HOLD) begin
            n_st = RUN;
          end
        end
        STOP:  if (m_st == RUN) begin n_st = HOLD; halt = 1'b1; end
        default: ;
      endcase
    end
    if ((m_st == RUN) && !halt) begin
`ifdef TIMER_CTRL_PRESCALER_EN
      tick  = (m_pre == PD - 1);
      n_pre = tick ? 0 : m_pre + 1;
`else
      tick = 1'b1;
`endif
      if (tick) begin
        if (m_cnt != m_term) begin
          n_cnt = m_cnt + 1'b1;
        end else if (m_per) begin
          n_cnt = '0; n_term = m_sh; e.rip = 1'b1;
        end else begin
          n_st = IDLE; e.dn = 1'b1;
        end
      end
    end
    e.cnt  = n_cnt;
    e.busy = (n_st == RUN);
    q.push_back(e);
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b0;
    m_st = n_st; m_cnt = n_cnt; m_term = n_term; m_sh = n_sh; m_per = n_per; m_pre = n_pre;
    compare_out("model");
  endtask

  task automatic idle();
    cyc(1'b0, START, '0, 1'b0);
  endtask

  initial begin
    int ndone;
    int nrip;
    int last;
    syn_rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = START;
    cmd_bus.cmd_data  = '0;
    cmd_bus.periodic  = 1'b0;
    reset_cyc(1'b0, START);
    reset_cyc(1'b0, START);

`ifdef TIMER_CTRL_PRESCALER_EN
    cyc(1'b1, LOAD, 8'd1, 1'b0);
    cyc(1'b1, START, '0, 1'b1);
    nrip = 0;
    last = -1;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (ripple) begin
        nrip++;
        if (last >= 0) chk("presc_period", i - last, 8);
        last = i;
      end
    end
    chk("presc_ripples", nrip, 5);
`else
    // Periodic run with terminal 3.
    cyc(1'b1, LOAD, 8'd3, 1'b0);
    cyc(1'b1, START, '0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      idle();
      chk("p3_count", count, seq3[i]);
      chk("p3_ripple", ripple, rip3[i]);
    end

    // Pause at 2, resume.
    idle();
    cyc(1'b1, STOP, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("hold_count", count, 2);
      chk("hold_busy", busy, 0);
    end
    cyc(1'b1, START, '0, 1'b0);
    chk("resume_count", count, 2);
    idle();
    chk("resume_count3", count, 3);
    idle();
    chk("resume_wrap", {count, ripple}, {8'd0, 1'b1});

    // New terminal loaded mid-period.
    cyc(1'b1, LOAD, 8'd7, 1'b0);
    for (int i = 0; i < 3; i++) idle();
    chk("load7_old_wrap", {count, ripple}, {8'd0, 1'b1});
    for (int i = 0; i < 7; i++) idle();
    chk("load7_top", count, 7);
    cyc(1'b1, START, '0, 1'b1);
    chk("term_ready", last_ready, 0);
    chk("load7_wrap", {count, ripple}, {8'd0, 1'b1});
    cyc(1'b1, START, '0, 1'b1);
    chk("after_term_ready", last_ready, 1);
    chk("start_in_run", {count, busy}, {8'd1, 1'b1});

    // Reset mid-run overrides the command; terminal returns to 255.
    reset_cyc(1'b1, STOP);
    chk("rst_outputs", {count, busy, ripple, done}, 11'd0);
    cyc(1'b1, START, '0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 260; i++) begin
      idle();
      if (done) ndone++;
    end
    chk("t255_done_count", ndone, 1);
    chk("t255_final", count, 255);

    // One-shot with terminal 5.
    cyc(1'b1, LOAD, 8'd5, 1'b0);
    cyc(1'b1, START, '0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (done) ndone++;
    end
    chk("os5_done_count", ndone, 1);
    chk("os5_count", count, 5);
    chk("os5_busy", busy, 0);

    // CLEAR mid-run keeps the terminal.
    cyc(1'b1, START, '0, 1'b1);
    for (int i = 0; i < 3; i++) idle();
    cyc(1'b1, CLEAR, '0, 1'b0);
    chk("clear_out", {count, busy}, {8'd0, 1'b0});
    cyc(1'b1, START, '0, 1'b1);
    for (int i = 0; i < 6; i++) idle();
    chk("clear_term_kept", {count, ripple}, {8'd0, 1'b1});

    // Terminal 0: ripple every tick, then done after one tick.
    cyc(1'b1, CLEAR, '0, 1'b0);
    cyc(1'b1, LOAD, 8'd0, 1'b0);
    cyc(1'b1, START, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t0_ripple", {count, ripple}, {8'd0, 1'b1});
    end
    reset_cyc(1'b0, START);
    cyc(1'b1, LOAD, 8'd0, 1'b0);
    cyc(1'b1, START, '0, 1'b0);
    idle();
    chk("t0_oneshot", {count, busy, done}, {8'd0, 1'b0, 1'b1});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
